// File: rtl/apb_req_arbiter.sv
// Round-robin APB master: NREQ requesters share one completer on _PSEL1, one SETUP->ACCESS transfer per grant.
// Latency: accept at E0, SETUP E0..E1, ACCESS from E1, rsp_valid pulse the cycle after _PREADY (or after timeout).
// Backpressure: req_ready is only offered in IDLE; a stalled completer holds the bus until _PREADY or TIMEOUT.
module apb_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                _PCLK,
  input  logic                _PRESET,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_write,
  input  logic [NREQ*32-1:0]  req_addr,
  input  logic [NREQ*32-1:0]  req_wdata,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic                _PSEL1,
  output logic                _PENABLE,
  output logic                _PWRITE,
  output logic [31:0]         _PADDR,
  output logic [31:0]         _PWDATA,
  input  logic [31:0]         _PRDATA,
  input  logic                _PREADY,
  input  logic                _PSLVERR
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_q;
  logic [IW-1:0] gnt_idx;
  logic          gnt_vld;
  logic [CW-1:0] to_cnt;
  logic [CW-1:0] to_cnt_nxt;
  logic          to_expired;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    return IW'((int'(base) + off) % NREQ);
  endfunction

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(rr_ptr, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_vld) req_ready = NREQ'(1) << gnt_idx;
  end

  assign to_cnt_nxt = to_cnt + 1'b1;
  assign to_expired = (TIMEOUT != 0) && (to_cnt_nxt == CW'(TIMEOUT));

  always_ff @(posedge _PCLK or posedge _PRESET) begin
    if (_PRESET) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_q     <= '0;
      to_cnt    <= '0;
      _PSEL1    <= 1'b0;
      _PENABLE  <= 1'b0;
      _PWRITE   <= 1'b0;
      _PADDR    <= '0;
      _PWDATA   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            _PWRITE  <= req_write[gnt_idx];
            _PADDR   <= req_addr[32*gnt_idx +: 32];
            _PWDATA  <= req_wdata[32*gnt_idx +: 32];
            gnt_q    <= gnt_idx;
            rr_ptr   <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            _PSEL1   <= 1'b1;
            _PENABLE <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          to_cnt   <= '0;
          _PENABLE <= 1'b1;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (_PREADY) begin
            rsp_valid <= NREQ'(1) << gnt_q;
            rsp_err   <= _PSLVERR;
            rsp_rdata <= (!_PWRITE && !_PSLVERR) ? _PRDATA : '0;
            _PSEL1    <= 1'b0;
            _PENABLE  <= 1'b0;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt_nxt;
            if (to_expired) begin
              rsp_valid <= NREQ'(1) << gnt_q;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              _PSEL1    <= 1'b0;
              _PENABLE  <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          _PSEL1   <= 1'b0;
          _PENABLE <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: two requesters, a 5-word APB completer model with an optional stall,
// and a scoreboard filled at each handshake and drained on each rsp_valid pulse.
module tb_apb_req_arbiter;

  logic        _PCLK;
  logic        _PRESET;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        _PSEL1, _PENABLE, _PWRITE;
  logic [31:0] _PADDR, _PWDATA, _PRDATA;
  logic        _PREADY, _PSLVERR;
  logic        stall;

  apb_req_arbiter #(.NREQ(2), .TIMEOUT(15)) dut (
    ._PCLK(_PCLK), ._PRESET(_PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    ._PSEL1(_PSEL1), ._PENABLE(_PENABLE), ._PWRITE(_PWRITE), ._PADDR(_PADDR), ._PWDATA(_PWDATA),
    ._PRDATA(_PRDATA), ._PREADY(_PREADY), ._PSLVERR(_PSLVERR)
  );

  initial _PCLK = 1'b0;
  always #5 _PCLK = ~_PCLK;

  // Completer: DEPTH=5, zero wait states unless stalled, error outside the range.
  logic [31:0] cmem [0:7];
  logic        in_rng;
  assign in_rng   = (_PADDR < 32'd5);
  assign _PREADY  = !stall;
  assign _PSLVERR = _PSEL1 && _PENABLE && !in_rng;
  assign _PRDATA  = in_rng ? cmem[_PADDR[2:0]] : 32'hBAD0_BAD0;
  always @(posedge _PCLK)
    if (_PSEL1 && _PENABLE && _PREADY && _PWRITE && in_rng) cmem[_PADDR[2:0]] <= _PWDATA;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          grant_log[$];
  logic [31:0] ref_mem [0:7];
  int          acc_cnt = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response check first, then handshake capture, so a grant in the rsp_valid cycle queues behind it.
  always @(negedge _PCLK) begin
    if (!_PRESET) begin
      chk("ready_onehot", {31'd0, $countones(req_ready) <= 1}, 32'd1);
      if (rsp_valid != 2'b00) begin
        if (sb.size() == 0) chk("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
        else begin
          e = sb.pop_front();
          chk("rsp_valid", {30'd0, rsp_valid}, 32'd1 << e.idx);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          logic [31:0] a, rd;
          logic        er;
          a  = req_addr[32*i +: 32];
          er = stall || (a >= 32'd5);
          rd = 32'd0;
          if (req_write[i]) begin
            if (!er) ref_mem[a[2:0]] = req_wdata[32*i +: 32];
          end else if (!er) rd = ref_mem[a[2:0]];
          sb.push_back('{idx: i, rdata: rd, err: er});
          grant_log.push_back(i);
          acc_cnt++;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid[i]            = v;
    req_write[i]            = w;
    req_addr[32*i +: 32]    = a;
    req_wdata[32*i +: 32]   = d;
  endtask

  task automatic wait_acc(input int target, input string tag);
    for (int c = 0; c < 50; c++) begin
      @(posedge _PCLK);
      if (acc_cnt >= target) break;
    end
    #1;
    chk(tag, {31'd0, acc_cnt >= target}, 32'd1);
  endtask

  task automatic wait_rsp(input string tag);
    for (int c = 0; c < 60; c++) begin
      if (sb.size() == 0) break;
      @(posedge _PCLK);
    end
    #1;
    chk(tag, sb.size(), 32'd0);
  endtask

  int base_g;
  int base_a;
  int pen;

  initial begin
    _PRESET   = 1'b1;
    stall     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge _PCLK);
    @(negedge _PCLK);
    chk("rst_psel", {31'd0, _PSEL1}, 32'd0);
    chk("rst_penable", {31'd0, _PENABLE}, 32'd0);
    chk("rst_pwrite", {31'd0, _PWRITE}, 32'd0);
    chk("rst_paddr", _PADDR, 32'd0);
    chk("rst_pwdata", _PWDATA, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    _PRESET = 1'b0;
    @(posedge _PCLK); #1;

    // Write then read back through requester 0.
    set_req(0, 1'b1, 1'b1, 32'd3, 32'hDEADBEEF);
    wait_acc(acc_cnt + 1, "t1_wr_acc");
    set_req(0, 1'b1, 1'b0, 32'd3, 32'd0);
    wait_acc(acc_cnt + 1, "t1_rd_acc");
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_rsp("t1_drain");
    repeat (3) @(posedge _PCLK); #1;
    chk("t1_rdata_hold", rsp_rdata, 32'hDEADBEEF);

    // Out-of-range read from requester 1.
    set_req(1, 1'b1, 1'b0, 32'h40, 32'd0);
    wait_acc(acc_cnt + 1, "t3_acc");
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_rsp("t3_drain");
    chk("t3_rdata", rsp_rdata, 32'd0);
    chk("t3_err", {31'd0, rsp_err}, 32'd1);

    // Both continuously valid: grants alternate starting at 0.
    base_g = grant_log.size();
    set_req(0, 1'b1, 1'b1, 32'd1, 32'h1111_0000);
    set_req(1, 1'b1, 1'b0, 32'd1, 32'd0);
    wait_acc(acc_cnt + 6, "t2_acc6");
    req_valid = 2'b00;
    wait_rsp("t2_drain");
    for (int k = 0; k < 6; k++)
      chk($sformatf("t2_grant%0d", k), grant_log[base_g + k], k % 2);

    // Requester 0 pulses valid while requester 1 is served; it must never be granted.
    base_a = acc_cnt;
    set_req(1, 1'b1, 1'b0, 32'd3, 32'd0);
    wait_acc(acc_cnt + 1, "t6_acc");
    req_valid = 2'b00;
    set_req(0, 1'b1, 1'b0, 32'd0, 32'd0);
    @(posedge _PCLK); #1;
    req_valid = 2'b00;
    repeat (10) @(posedge _PCLK); #1;
    chk("t6_no_extra_acc", acc_cnt, base_a + 1);
    chk("t6_psel_idle", {31'd0, _PSEL1}, 32'd0);
    wait_rsp("t6_drain");

    // Stuck completer: exactly 15 ACCESS cycles, then abort with error.
    stall = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'd0, 32'd0);
    wait_acc(acc_cnt + 1, "t4_acc");
    req_valid = 2'b00;
    pen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge _PCLK);
      if (_PENABLE) pen++;
      else if (pen > 0) break;
    end
    chk("t4_penable_cycles", pen, 32'd15);
    chk("t4_psel_after", {31'd0, _PSEL1}, 32'd0);
    chk("t4_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("t4_rsp_err", {31'd0, rsp_err}, 32'd1);
    stall = 1'b0;
    wait_rsp("t4_drain");

    // Reset in ACCESS: bus drops at once, transfer vanishes, arbitration restarts at req0.
    stall = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'd1, 32'd0);
    wait_acc(acc_cnt + 1, "t5_acc");
    req_valid = 2'b00;
    for (int c = 0; c < 10; c++) begin
      @(negedge _PCLK);
      if (_PENABLE) break;
    end
    chk("t5_in_access", {31'd0, _PENABLE}, 32'd1);
    #2 _PRESET = 1'b1;
    #1;
    chk("t5_psel_async", {31'd0, _PSEL1}, 32'd0);
    chk("t5_penable_async", {31'd0, _PENABLE}, 32'd0);
    sb.delete();
    stall = 1'b0;
    @(posedge _PCLK); #1;
    chk("t5_no_rsp", {30'd0, rsp_valid}, 32'd0);
    @(negedge _PCLK);
    _PRESET = 1'b0;
    @(posedge _PCLK); #1;
    set_req(0, 1'b1, 1'b0, 32'd3, 32'd0);
    set_req(1, 1'b1, 1'b0, 32'd1, 32'd0);
    wait_acc(acc_cnt + 1, "t5_acc_a");
    chk("t5_first_grant", grant_log[grant_log.size() - 1], 32'd0);
    req_valid[0] = 1'b0;
    wait_acc(acc_cnt + 1, "t5_acc_b");
    chk("t5_second_grant", grant_log[grant_log.size() - 1], 32'd1);
    req_valid = 2'b00;
    wait_rsp("t5_drain");

    repeat (3) @(posedge _PCLK);
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
